ray_dispatcher: RTL and testbench
=================================

RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 Parameter H_RES, default 160, horizontal pixels per frame.
REQ-002 Parameter V_RES, default 120, vertical pixels per frame.
REQ-003 Parameter FOCAL, default 128, constant ray z component.
REQ-004 Parameter CORE_LATENCY, default 4, cycles from pixel presented to hit flag valid at intersection core.
REQ-005 Parameter FIFO_DEPTH, default 8, result buffer entries (power of two, >= CORE_LATENCY).
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse; begins a frame when idle.
REQ-009 pixel  out  Pixel_s  ray direction presented to intersection core.
REQ-010 less_than_zero  in  1  core result; 1 = miss, 0 = hit.
REQ-011 fb_valid  out  1  framebuffer write request.
REQ-012 fb_ready  in  1  framebuffer accepts write when high with fb_valid.
REQ-013 fb_addr  out  $clog2(H_RES*V_RES)  linear pixel address.
REQ-014 fb_data  out  8  pixel colour.
REQ-015 busy  out  1  high from accepted start until done.
REQ-016 done  out  1  one-cycle pulse after last framebuffer write accepted.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN, FINISH; IDLE->ISSUE on start; ISSUE->DRAIN after pixel (H_RES-1,V_RES-1) issued; DRAIN->FINISH when no rays in flight and FIFO empty; FINISH->IDLE after one cycle with done=1.
REQ-018 start while busy is ignored.
REQ-019 Scan raster order: x 0..H_RES-1 inner, y 0..V_RES-1 outer; x wraps to 0 and y increments on the same cycle.
REQ-020 pixel.x = x - H_RES/2, pixel.y = V_RES/2 - y, pixel.z = FOCAL, all signed at Pixel_s field width.
REQ-021 One ray issued per cycle in ISSUE only when (in_flight + fifo_count) < FIFO_DEPTH; otherwise pixel held and counters stall.
REQ-022 Each issued ray pushes a valid bit plus fb_addr into a CORE_LATENCY-deep tag shift register; non-issue cycles push valid=0.
REQ-023 When tag pipeline output valid=1, the same-cycle less_than_zero is sampled and {addr, colour} written to the FIFO.
REQ-024 Colour = 8'hFF on hit (less_than_zero=0), 8'h00 on miss.
REQ-025 fb_addr = y*H_RES + x computed at issue time, carried with tag.
REQ-026 fb_valid = FIFO non-empty; fb_addr/fb_data = FIFO head; pop on fb_valid && fb_ready.
REQ-027 fb_valid/fb_addr/fb_data stable while fb_valid && !fb_ready.
REQ-028 Simultaneous FIFO push and pop permitted at any occupancy including full; credit rule guarantees no overflow.
REQ-029 in_flight counts valid bits in tag pipeline; inc on issue, dec on retire, unchanged when both same cycle.
REQ-030 Total fb writes per frame exactly H_RES*V_RES; order equals raster order.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE, x=y=0, tag pipeline valid bits=0, in_flight=0, FIFO empty.
REQ-032 Reset outputs: pixel=0, fb_valid=0, fb_addr=0, fb_data=0, busy=0, done=0.
REQ-033 Reset mid-frame aborts the frame; no further fb writes; next start begins at pixel (0,0).

Structure
REQ-034 Pixel_s, colour constants HIT_COLOR/MISS_COLOR and state enum defined in shared types package.
REQ-035 Result buffer is sub-module sync_fifo (parameterised width/depth, count output); everything else inline.

Verification
REQ-036 Reset then start with fb_ready=1, H_RES=4, V_RES=2, model core returning hit for all -> 8 writes, addr 0..7, data 8'hFF, done pulses once.
REQ-037 First issued pixel with defaults -> pixel = (-80, 60, 128); last = (79, -59, 128).
REQ-038 fb_ready held 0 for 50 cycles mid-frame -> issue stalls at in_flight+count=8, no FIFO overflow, outputs stable, no lost or duplicated addresses.
REQ-039 fb_ready toggling every cycle, core returning miss for odd x -> data alternates 8'hFF/8'h00 in raster order.
REQ-040 rst_n low at cycle 20 of frame, then start -> busy=0 during reset, next first write addr 0.
REQ-041 start pulsed while busy -> ignored; exactly H_RES*V_RES writes and one done.

Source files
------------

// File: rtl/ray_dispatcher_pkg.sv
// Shared types for the ray dispatcher: ray direction struct, colours, FSM codes.
package ray_dispatcher_pkg;

   localparam int PIX_W = 12;

   typedef struct packed {
      logic signed [PIX_W-1:0] x;
      logic signed [PIX_W-1:0] y;
      logic signed [PIX_W-1:0] z;
   } Pixel_s;

   localparam logic [7:0] HIT_COLOR  = 8'hFF;
   localparam logic [7:0] MISS_COLOR = 8'h00;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ISSUE  = 2'd1;
   localparam state_t ST_DRAIN  = 2'd2;
   localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/ray_dispatcher_if.sv
// Bus between the dispatcher, the intersection core and the framebuffer.
interface ray_dispatcher_if #(
   parameter int ADDR_W = 15
);
   import ray_dispatcher_pkg::*;

   Pixel_s            pixel;
   logic              less_than_zero;
   logic              fb_valid;
   logic              fb_ready;
   logic [ADDR_W-1:0] fb_addr;
   logic [7:0]        fb_data;

   modport master (
      output pixel,
      input  less_than_zero,
      output fb_valid,
      input  fb_ready,
      output fb_addr,
      output fb_data
   );

   modport slave (
      input  pixel,
      output less_than_zero,
      input  fb_valid,
      output fb_ready,
      input  fb_addr,
      input  fb_data
   );

endinterface

// File: rtl/ray_dispatcher_fifo.sv
// Synchronous FIFO holding retired {addr, colour} results until the framebuffer takes them.
// Push while full is accepted only together with a pop in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head reads as zero when empty so the unreset storage never reaches the outputs.
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage write.
   // NOTE: the data array has no reset; validity is tracked by count, and resetting RAM blocks the use of memory macros.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally for power-of-two DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ray_dispatcher.sv
// Ray dispatcher: scans the frame in raster order, issues one ray direction per cycle
// to a fixed-latency intersection core, tags results with their address and buffers
// them for the framebuffer. Issue is credit-limited so the result buffer never overflows.
module ray_dispatcher
   import ray_dispatcher_pkg::*;
#(
   parameter int H_RES        = 160,
   parameter int V_RES        = 120,
   parameter int FOCAL        = 128,
   parameter int CORE_LATENCY = 4,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   ray_dispatcher_if.master bus,
   output logic             busy,
   output logic             done
);
   localparam int ADDR_W = $clog2(H_RES * V_RES);
   localparam int X_W    = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int Y_W    = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int CRD_W  = CNT_W + 1;

   state_t                  state;
   logic [X_W-1:0]          x;
   logic [Y_W-1:0]          y;
   logic [ADDR_W-1:0]       addr;
   logic                    issue;
   logic                    last_x;
   logic                    last_y;
   logic [CORE_LATENCY-1:0] tag_valid;
   logic [ADDR_W-1:0]       tag_addr [CORE_LATENCY];
   logic                    retire;
   logic [CNT_W-1:0]        in_flight;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_empty;
   logic [CRD_W-1:0]        credit_used;
   logic [7:0]              colour;
   Pixel_s                  pix_c;

   assign last_x      = (x == X_W'(H_RES - 1));
   assign last_y      = (y == Y_W'(V_RES - 1));
   assign credit_used = CRD_W'(in_flight) + CRD_W'(fifo_count);
   assign issue       = (state == ST_ISSUE) && (credit_used < CRD_W'(FIFO_DEPTH));
   assign retire      = tag_valid[CORE_LATENCY-1];
   assign colour      = bus.less_than_zero ? MISS_COLOR : HIT_COLOR;
   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_FINISH);

   // Ray direction for the current scan position; zero outside ISSUE.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pix_c = '0;
      if (state == ST_ISSUE) begin
         pix_c.x = PIX_W'(x) - PIX_W'(H_RES / 2);
         pix_c.y = PIX_W'(V_RES / 2) - PIX_W'(y);
         pix_c.z = PIX_W'(FOCAL);
      end
   end
   assign bus.pixel = pix_c;

   // Frame FSM and raster counters; counters advance only on an issued ray.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         x     <= '0;
         y     <= '0;
         addr  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_ISSUE;
                  x     <= '0;
                  y     <= '0;
                  addr  <= '0;
               end
            end
            ST_ISSUE: begin
               if (issue) begin
                  if (last_x) begin
                     x <= '0;
                     if (last_y) begin
                        y     <= '0;
                        state <= ST_DRAIN;
                     end else begin
                        y <= y + 1'b1;
                     end
                  end else begin
                     x <= x + 1'b1;
                  end
                  addr <= (last_x && last_y) ? '0 : addr + 1'b1;
               end
            end
            ST_DRAIN: begin
               if ((in_flight == '0) && fifo_empty) state <= ST_FINISH;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Tag valid bits track rays inside the core; they must clear on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= '0;
      end else begin
         tag_valid[0] <= issue;
         for (int i = 1; i < CORE_LATENCY; i++) tag_valid[i] <= tag_valid[i-1];
      end
   end

   // Tag addresses ride alongside the valid bits; only meaningful where valid is set.
   always_ff @(posedge clk) begin
      tag_addr[0] <= addr;
      for (int i = 1; i < CORE_LATENCY; i++) tag_addr[i] <= tag_addr[i-1];
   end

   // Rays currently inside the core; issue and retire in the same cycle cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_flight <= '0;
      end else begin
         case ({issue, retire})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: ;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (ADDR_W + 8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (retire),
      .push_data ({tag_addr[CORE_LATENCY-1], colour}),
      .pop       (bus.fb_valid && bus.fb_ready),
      .head      ({bus.fb_addr, bus.fb_data}),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bus.fb_valid = !fifo_empty;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench: a small 4x2 dispatcher and a default-size one share the clock and reset.
// Expected writes are queued when a frame is started; monitors pop and compare on each
// accepted framebuffer write. A pipelined core model answers each presented pixel.
module tb_ray_dispatcher;
   import ray_dispatcher_pkg::*;

   localparam int SH    = 4;
   localparam int SV    = 2;
   localparam int DH    = 160;
   localparam int DV    = 120;
   localparam int LAT   = 4;
   localparam int DEPTH = 8;
   localparam int SA_W  = $clog2(SH * SV);
   localparam int DA_W  = $clog2(DH * DV);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start_s = 1'b0;
   logic start_d = 1'b0;
   logic busy_s, done_s, busy_d, done_d;
   logic miss_odd = 1'b0;
   int   rdy_mode_s = 0;   // 0 always ready, 1 toggle every cycle, 2 held low
   int   rdy_mode_d = 0;

   always #5 clk = ~clk;

   ray_dispatcher_if #(.ADDR_W(SA_W)) bus_s ();
   ray_dispatcher_if #(.ADDR_W(DA_W)) bus_d ();

   ray_dispatcher #(
      .H_RES(SH), .V_RES(SV), .FOCAL(128), .CORE_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .bus(bus_s), .busy(busy_s), .done(done_s)
   );

   ray_dispatcher dut_d (
      .clk(clk), .rst_n(rst_n), .start(start_d), .bus(bus_d), .busy(busy_d), .done(done_d)
   );

   // Core model: miss decided from the presented pixel, delivered LAT cycles later.
   logic ltz_s [LAT];
   logic ltz_d [LAT];
   always @(posedge clk) begin
      ltz_s[0] <= miss_odd & bus_s.pixel.x[0];
      ltz_d[0] <= miss_odd & bus_d.pixel.x[0];
      for (int i = 1; i < LAT; i++) begin
         ltz_s[i] <= ltz_s[i-1];
         ltz_d[i] <= ltz_d[i-1];
      end
   end
   assign bus_s.less_than_zero = ltz_s[LAT-1];
   assign bus_d.less_than_zero = ltz_d[LAT-1];

   // Framebuffer ready pattern, updated just after each rising edge.
   always @(posedge clk) begin
      #1;
      bus_s.fb_ready = (rdy_mode_s == 0) ? 1'b1 : (rdy_mode_s == 1) ? !bus_s.fb_ready : 1'b0;
      bus_d.fb_ready = (rdy_mode_d == 0) ? 1'b1 : (rdy_mode_d == 1) ? !bus_d.fb_ready : 1'b0;
   end

   logic [63:0] exp_s [$];
   logic [63:0] exp_d [$];
   int checks = 0;
   int errors = 0;
   int wr_s = 0, wr_d = 0, done_cnt_s = 0, done_cnt_d = 0;
   Pixel_s last_pix_d = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Small-DUT monitor: hold stability, write ordering/content, done pulses.
   logic        hold_s = 1'b0;
   logic [63:0] held_s;
   always @(negedge clk) begin
      logic [63:0] cur;
      cur = 64'({bus_s.fb_valid, bus_s.fb_addr, bus_s.fb_data});
      if (!rst_n) begin
         hold_s = 1'b0;
      end else begin
         if (hold_s) check("s_hold", cur, held_s);
         if (bus_s.fb_valid && bus_s.fb_ready) begin
            wr_s++;
            if (exp_s.size() == 0) check("s_unexpected_write", 64'(exp_s.size()), 64'd1);
            else check("s_write", 64'({bus_s.fb_addr, bus_s.fb_data}), exp_s.pop_front());
         end
         hold_s = bus_s.fb_valid && !bus_s.fb_ready;
         held_s = cur;
         if (done_s) done_cnt_s++;
      end
   end

   // Default-DUT monitor: same checks plus tracking of the last presented ray.
   logic        hold_d = 1'b0;
   logic [63:0] held_d;
   always @(negedge clk) begin
      logic [63:0] cur;
      cur = 64'({bus_d.fb_valid, bus_d.fb_addr, bus_d.fb_data});
      if (!rst_n) begin
         hold_d = 1'b0;
      end else begin
         if (hold_d) check("d_hold", cur, held_d);
         if (bus_d.fb_valid && bus_d.fb_ready) begin
            wr_d++;
            if (exp_d.size() == 0) check("d_unexpected_write", 64'(exp_d.size()), 64'd1);
            else check("d_write", 64'({bus_d.fb_addr, bus_d.fb_data}), exp_d.pop_front());
         end
         hold_d = bus_d.fb_valid && !bus_d.fb_ready;
         held_d = cur;
         if (done_d) done_cnt_d++;
         if (bus_d.pixel != '0) last_pix_d = bus_d.pixel;
      end
   end

   // Queue the whole frame's expected writes: raster address, white unless odd x misses.
   task automatic push_frame(input bit big, input bit odd_miss);
      int h;
      int n;
      h = big ? DH : SH;
      n = big ? DH * DV : SH * SV;
      for (int i = 0; i < n; i++) begin
         logic [7:0]  d;
         logic [63:0] e;
         d = (odd_miss && ((i % h) % 2 == 1)) ? 8'h00 : 8'hFF;
         e = (64'(i) << 8) | 64'(d);
         if (big) exp_d.push_back(e);
         else     exp_s.push_back(e);
      end
   endtask

   // One-cycle start pulse; returns just after the edge that samples it.
   task automatic pulse_start(input bit big);
      if (big) start_d = 1'b1;
      else     start_s = 1'b1;
      @(posedge clk); #1;
      start_d = 1'b0;
      start_s = 1'b0;
   endtask

   // Bounded wait for done, then confirm a single done, the write count and an empty queue.
   task automatic wait_frame(input bit big, input int budget, input int n_writes);
      for (int i = 0; i < budget && (big ? done_cnt_d : done_cnt_s) == 0; i++) @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      if (big) begin
         check("d_done_once", 64'(done_cnt_d), 64'd1);
         check("d_write_count", 64'(wr_d), 64'(n_writes));
         check("d_queue_empty", 64'(exp_d.size()), 64'd0);
         check("d_idle_after", 64'(busy_d), 64'd0);
      end else begin
         check("s_done_once", 64'(done_cnt_s), 64'd1);
         check("s_write_count", 64'(wr_s), 64'(n_writes));
         check("s_queue_empty", 64'(exp_s.size()), 64'd0);
         check("s_idle_after", 64'(busy_s), 64'd0);
      end
   endtask

   initial begin
      Pixel_s exp_pix;
      Pixel_s p10;
      int     px;
      int     py;

      // Reset values on both instances.
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_pixel", 64'(bus_s.pixel), 64'd0);
      check("rst_s_fb_valid", 64'(bus_s.fb_valid), 64'd0);
      check("rst_s_fb_addr_data", 64'({bus_s.fb_addr, bus_s.fb_data}), 64'd0);
      check("rst_s_busy", 64'(busy_s), 64'd0);
      check("rst_s_done", 64'(done_s), 64'd0);
      check("rst_d_pixel", 64'(bus_d.pixel), 64'd0);
      check("rst_d_fb_valid", 64'(bus_d.fb_valid), 64'd0);
      check("rst_d_fb_addr_data", 64'({bus_d.fb_addr, bus_d.fb_data}), 64'd0);
      check("rst_d_busy", 64'(busy_d), 64'd0);
      check("rst_d_done", 64'(done_d), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 4x2 frame, all hits, framebuffer always ready.
      push_frame(1'b0, 1'b0);
      pulse_start(1'b0);
      check("s_busy_after_start", 64'(busy_s), 64'd1);
      wait_frame(1'b0, 200, SH * SV);

      // Second start while busy must be ignored.
      done_cnt_s = 0; wr_s = 0;
      push_frame(1'b0, 1'b0);
      pulse_start(1'b0);
      repeat (3) @(posedge clk);
      #1;
      pulse_start(1'b0);
      wait_frame(1'b0, 200, SH * SV);

      // Ready toggling each cycle, odd columns miss.
      done_cnt_s = 0; wr_s = 0;
      miss_odd = 1'b1;
      rdy_mode_s = 1;
      push_frame(1'b0, 1'b1);
      pulse_start(1'b0);
      wait_frame(1'b0, 300, SH * SV);
      rdy_mode_s = 0;
      miss_odd = 1'b0;

      // Default-size frame: first ray, 50-cycle back-pressure stall, last ray.
      push_frame(1'b1, 1'b0);
      pulse_start(1'b1);
      exp_pix = '{x: -12'sd80, y: 12'sd60, z: 12'sd128};
      check("d_first_pixel", 64'(bus_d.pixel), 64'(exp_pix));
      repeat (300) @(posedge clk);
      #1;
      rdy_mode_d = 2;
      repeat (10) @(negedge clk);
      p10 = bus_d.pixel;
      repeat (40) @(negedge clk);
      check("d_stall_pixel_held", 64'(bus_d.pixel), 64'(p10));
      check("d_stall_fb_valid", 64'(bus_d.fb_valid), 64'd1);
      px = int'(bus_d.pixel.x) + DH / 2;
      py = DV / 2 - int'(bus_d.pixel.y);
      check("d_stall_credit_limit", 64'(py * DH + px), 64'(wr_d + DEPTH));
      @(posedge clk); #1;
      rdy_mode_d = 0;
      wait_frame(1'b1, 25000, DH * DV);
      exp_pix = '{x: 12'sd79, y: -12'sd59, z: 12'sd128};
      check("d_last_pixel", 64'(last_pix_d), 64'(exp_pix));

      // Reset 20 cycles into a frame, then a fresh frame from address 0.
      done_cnt_d = 0; wr_d = 0;
      push_frame(1'b1, 1'b0);
      pulse_start(1'b1);
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy_d), 64'd0);
      check("mid_rst_fb_valid", 64'(bus_d.fb_valid), 64'd0);
      check("mid_rst_pixel", 64'(bus_d.pixel), 64'd0);
      check("mid_rst_done", 64'(done_d), 64'd0);
      exp_d.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      done_cnt_d = 0; wr_d = 0;
      @(posedge clk); #1;
      push_frame(1'b1, 1'b0);
      pulse_start(1'b1);
      wait_frame(1'b1, 25000, DH * DV);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
